// File: rtl/wb_master_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_bridge_pkg
//   Shared definitions for the Wishbone classic master bridge: FSM state
//   encodings, the all-lanes byte-select value, the default bus timeout and the
//   read data returned alongside an error response.
//   Optional feature macro used by the bridge: WB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package wb_master_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // waiting for a CPU request, grant offered
    ST_BUS  = 2'b01,  // Wishbone cycle in flight, waiting for ack
    ST_RESP = 2'b10   // one-cycle completion pulse toward the CPU
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL             = 4'hF;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] WB_ERR_RDATA           = 32'h0;

endpackage

// File: rtl/wb_master_bridge_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_master_bridge_timeout_cnt
//   Bus-cycle watchdog for the bridge. Only exists when WB_TIMEOUT_EN is
//   defined; the default build has no counter at all.
//   Ports:
//     clk_i      clock, rising edge
//     rst_i      synchronous active-high reset
//     clear_i    restart the count (asserted on entry into the bus phase)
//     enable_i   count one cycle spent in the bus phase
//     expired_o  LIMIT bus cycles have elapsed without completion
// -----------------------------------------------------------------------------
`ifdef WB_TIMEOUT_EN
module wb_master_bridge_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (LIMIT < 256) ? 8 : 32;

  logic [CW-1:0] cnt_q;

  // The count starts at zero in the first bus cycle, so reaching LIMIT-1
  // means the current edge closes the LIMIT-th cycle without an ack.
  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//   Wishbone classic master. Converts single-beat CPU load/store requests into
//   Wishbone cycles toward peripheral slaves. One transfer outstanding at a
//   time; all bus and response outputs are registered.
//   Optional feature: define WB_TIMEOUT_EN to abort a bus cycle that sees no
//   ack within TIMEOUT_CYCLES cycles (reported as an error).
//   Ports:
//     clk_i, rst_i            clock / synchronous active-high reset
//     cpu_req_i, cpu_gnt_o    request handshake (accept = req & gnt)
//     cpu_we_i, cpu_addr_i    direction and byte address (bits [1:0] ignored)
//     cpu_be_i, cpu_wdata_i   byte enables and write data
//     cpu_done_o              one-cycle completion pulse
//     cpu_rdata_o, cpu_err_o  response, valid with cpu_done_o, held afterwards
//     cyc_o, stb_o, adr_o, we_o, sel_o, dat_o   Wishbone master outputs
//     dat_i, ack_i                              Wishbone slave response
// -----------------------------------------------------------------------------
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  output logic          cpu_gnt_o,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [3:0]    cpu_be_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic          cpu_done_o,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_err_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic [AW-1:0] adr_o,
  output logic          we_o,
  output logic [3:0]    sel_o,
  output logic [31:0]   dat_o,
  input  logic [31:0]   dat_i,
  input  logic          ack_i
);

  state_e        state_q, state_d;
  logic          accept;
  logic          bad_be;
  logic          bus_ack;
  logic          timeout_hit;

  logic          cyc_q;
  logic          done_q;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  assign cpu_gnt_o = (state_q == ST_IDLE) && !rst_i;
  assign accept    = cpu_req_i && cpu_gnt_o;
  assign bad_be    = (cpu_be_i == 4'h0);
  // Acks outside the bus phase are stray and must not complete anything.
  assign bus_ack   = (state_q == ST_BUS) && ack_i;

`ifdef WB_TIMEOUT_EN
  logic expired;

  wb_master_bridge_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (accept && !bad_be),
    .enable_i (state_q == ST_BUS),
    .expired_o(expired)
  );

  // An ack on the expiry edge is a normal completion, not a timeout.
  assign timeout_hit = (state_q == ST_BUS) && expired && !ack_i;
`else
  assign timeout_hit = 1'b0;
`endif

  // The address LSBs are word-aligned away; the timeout limit only matters
  // when the watchdog is built in.
  logic unused_ok;
  assign unused_ok = ^{cpu_addr_i[1:0], (TIMEOUT_CYCLES != 0)};

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = bad_be ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= 4'h0;
      dat_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Outputs are decoded from the next state so they leave a flop.
      cyc_q   <= (state_d == ST_BUS);
      done_q  <= (state_d == ST_RESP);

      if (accept) begin
        we_q  <= cpu_we_i;
        adr_q <= {cpu_addr_i[AW-1:2], 2'b00};
        sel_q <= cpu_be_i;
        dat_q <= cpu_wdata_i;
      end

      // Response registers change only when a completion is produced and
      // otherwise keep the last result for the CPU.
      if (accept && bad_be) begin
        rdata_q <= WB_ERR_RDATA;
        err_q   <= 1'b1;
      end else if (bus_ack) begin
        rdata_q <= we_q ? 32'h0 : dat_i;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q <= WB_ERR_RDATA;
        err_q   <= 1'b1;
      end
    end
  end

  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign adr_o       = adr_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;
  assign cpu_done_o  = done_q;
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;

endmodule
